image_readback: RTL and testbench

- Reader counterpart of the image capture buffer. It snapshots the packed 904-bit image (113 bytes, byte k = bits [k*8+7:k*8]) on a start pulse.
- It then streams the bytes out in ascending address order over a valid/ready handshake, toward the SPI/UART transmit path, for host-side echo and debug of the captured image.
- The buffer can be cleared and refilled while a readback is in progress, because streaming always uses the shadow copy.

---
 rtl/image_readback_pkg.sv | 16 +
 rtl/image_readback.sv | 129 ++++++++++++
 tb/tb_image_readback.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/image_readback_pkg.sv
// Shared image geometry and readback FSM state encoding, common to the
// capture buffer and the readback streamer.
package image_pkg;

  localparam int         IMG_WIDTH     = 30;
  localparam int         IMG_HEIGHT    = 30;
  localparam int         TOTAL_BITS    = 904;
  localparam logic [6:0] IMG_BYTE_SIZE = 7'd113;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } readback_state_t;

endpackage

// File: rtl/image_readback.sv
// Snapshots the packed capture image on start and streams it out byte by byte
// over valid/ready. Optional macro READBACK_CHECKSUM_EN appends an XOR byte.
module image_readback
  import image_pkg::*;
#(
  parameter int         TOTAL_BITS    = image_pkg::TOTAL_BITS,
  parameter logic [6:0] IMG_BYTE_SIZE = image_pkg::IMG_BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TOTAL_BITS-1:0] img_in,
  input  logic                  img_valid,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [6:0]            read_addr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [6:0] LAST_DATA = IMG_BYTE_SIZE - 7'd1;
`ifdef READBACK_CHECKSUM_EN
  // The checksum byte rides one address past the last image byte.
  localparam logic [6:0] LAST_ADDR = IMG_BYTE_SIZE;
`else
  localparam logic [6:0] LAST_ADDR = LAST_DATA;
`endif

  readback_state_t       state, state_nxt;
  logic [TOTAL_BITS-1:0] shadow;
  logic [6:0]            next_addr;
  logic [9:0]            next_idx;
  logic [7:0]            shadow_byte;
  logic [7:0]            next_byte;
  logic                  fire;
  logic                  last_fire;

  assign fire      = data_valid && data_ready;
  assign last_fire = fire && (read_addr == LAST_ADDR);
  assign next_addr = read_addr + 7'd1;
  assign next_idx  = {next_addr, 3'b000};
  assign busy      = (state == LOAD) || (state == STREAM);

  // Addresses past the image only occur for the checksum slot; keep the mux in range.
  assign shadow_byte = (next_addr < IMG_BYTE_SIZE) ? shadow[next_idx +: 8] : 8'h00;

`ifdef READBACK_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 8'h00;
    end else if (state == LOAD) begin
      csum <= 8'h00;
    end else if (state == STREAM && fire && !abort && read_addr <= LAST_DATA) begin
      csum <= csum ^ data_out;
    end
  end

  assign next_byte = (read_addr == LAST_DATA) ? (csum ^ data_out) : shadow_byte;
`else
  assign next_byte = shadow_byte;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && img_valid) state_nxt = LOAD;
      LOAD:    state_nxt = abort ? IDLE : STREAM;
      STREAM:  if (abort || last_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      read_addr  <= 7'd0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && img_valid) begin
            shadow    <= img_in;
            read_addr <= 7'd0;
          end
        end
        LOAD: begin
          if (abort) begin
            data_valid <= 1'b0;
            read_addr  <= 7'd0;
          end else begin
            data_out   <= shadow[7:0];
            data_valid <= 1'b1;
          end
        end
        STREAM: begin
          // Abort wins over a same-cycle handshake; that byte is dropped.
          if (abort) begin
            data_valid <= 1'b0;
            read_addr  <= 7'd0;
          end else if (last_fire) begin
            data_valid <= 1'b0;
            done       <= 1'b1;
            read_addr  <= 7'd0;
          end else if (fire) begin
            read_addr <= next_addr;
            data_out  <= next_byte;
          end
        end
        default: begin
          data_valid <= 1'b0;
          read_addr  <= 7'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_readback.sv
// Directed bench for image_readback: ramp stream, backpressure, guards,
// isolation, abort and mid-stream reset (plus checksum byte when enabled).
module tb_image_readback;
  import image_pkg::*;

`ifdef READBACK_CHECKSUM_EN
  localparam int NB = 114;
`else
  localparam int NB = 113;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [903:0] img_in;
  logic         img_valid;
  logic [7:0]   data_out;
  logic         data_valid;
  logic         data_ready;
  logic [6:0]   read_addr;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  image_readback dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .img_in     (img_in),
    .img_valid  (img_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .read_addr  (read_addr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [903:0] ramp_img();
    logic [903:0] r;
    for (int k = 0; k < 113; k++) r[k*8 +: 8] = k[7:0];
    return r;
  endfunction

  function automatic logic [903:0] fill_img(input logic [7:0] b);
    logic [903:0] r;
    for (int k = 0; k < 113; k++) r[k*8 +: 8] = b;
    return r;
  endfunction

  // Expected ramp byte, including the XOR checksum slot when it exists.
  function automatic logic [7:0] ramp_byte(input int i);
    logic [7:0] x;
    x = 8'h00;
    if (i < 113) return i[7:0];
    for (int k = 0; k < 113; k++) x = x ^ k[7:0];
    return x;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_addr(input int a);
    int n;
    n = 0;
    while (!(data_valid && read_addr == a[6:0]) && n < 500) begin
      tick();
      n++;
    end
    chk("wait_addr", (n < 500) ? 1 : 0, 1);
  endtask

  initial begin
    int cnt;
    int expi;
    int cyc;
    int seen_done;
    logic [7:0] last_b;
    logic [6:0] last_a;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    img_in = '0; img_valid = 1'b0; data_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_addr", read_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Ramp, with image change after capture and a stray start mid-stream.
    img_in = ramp_img(); img_valid = 1'b1; data_ready = 1'b1;
    pulse_start();
    img_in = fill_img(8'hFF);
    chk("lat1_busy", busy, 1);
    chk("lat1_valid", data_valid, 0);
    tick();
    chk("lat2_valid", data_valid, 1);
    for (int k = 0; k < NB; k++) begin
      chk("ramp_byte", data_out, ramp_byte(k));
      chk("ramp_addr", read_addr, k);
      start = (k == 40);
      tick();
    end
    start = 1'b0;
    chk("ramp_done", done, 1);
    chk("ramp_busy_fall", busy, 0);
    chk("ramp_valid_fall", data_valid, 0);
    tick();
    chk("ramp_done_pulse", done, 0);

    // Start without a full buffer is ignored.
    img_valid = 1'b0;
    pulse_start();
    chk("guard_busy", busy, 0);
    tick();
    chk("guard_busy2", busy, 0);
    chk("guard_valid", data_valid, 0);

    // Backpressure: ready pattern 1,0,0,1 repeating.
    img_in = ramp_img(); img_valid = 1'b1;
    pulse_start();
    cnt = 0; expi = 0; cyc = 0; seen_done = 0;
    while (cyc < 2000 && !seen_done) begin
      if (done) begin
        seen_done = 1;
      end else begin
        data_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        if (data_valid) begin
          chk("bp_byte", data_out, ramp_byte(expi));
          chk("bp_addr", read_addr, expi);
          if (data_ready) begin
            cnt++;
            expi++;
          end
        end
        tick();
        cyc++;
      end
    end
    chk("bp_done_seen", seen_done, 1);
    chk("bp_count", cnt, NB);
    chk("bp_valid_after", data_valid, 0);
    data_ready = 1'b1;

    // Abort on the same cycle as a fire at address 50.
    pulse_start();
    wait_addr(50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", data_valid, 0);
    chk("abort_addr", read_addr, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_done2", done, 0);
    pulse_start();
    tick();
    chk("restart_valid", data_valid, 1);
    chk("restart_byte", data_out, 0);
    chk("restart_addr", read_addr, 0);

    // Synchronous reset mid-stream.
    wait_addr(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_data_out", data_out, 0);
    chk("mrst_valid", data_valid, 0);
    chk("mrst_addr", read_addr, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);

`ifdef READBACK_CHECKSUM_EN
    // All-0x5A image: odd byte count leaves 0x5A as the checksum.
    img_in = fill_img(8'h5A);
    pulse_start();
    cnt = 0; cyc = 0; seen_done = 0; last_b = 8'h00; last_a = 7'd0;
    while (cyc < 500 && !seen_done) begin
      if (done) begin
        seen_done = 1;
      end else begin
        if (data_valid) begin
          cnt++;
          last_b = data_out;
          last_a = read_addr;
        end
        tick();
        cyc++;
      end
    end
    chk("cs_done_seen", seen_done, 1);
    chk("cs_count", cnt, 114);
    chk("cs_last_byte", last_b, 8'h5A);
    chk("cs_last_addr", last_a, 113);
`else
    last_b = 8'h00;
    last_a = 7'd0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
